seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//  Sequential unsigned restoring divider; the inverse operation to the team's 4-bit array multiplier.
//  - Accepts a DIVIDEND_W-bit dividend and a DIVISOR_W-bit divisor on a start pulse.
//  - Produces quotient and remainder after DIVIDEND_W iterations, one quotient bit per clock.
//  - Sits beside the multiplier in the arithmetic unit; check property: quotient*divisor + remainder == dividend.
// PARAMETERS
//  DIVIDEND_W  8  dividend and quotient width (>= DIVISOR_W)
//  DIVISOR_W   4  divisor and remainder width
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           asynchronous active-low reset
//  start        in   1           request; sampled only in IDLE
//  dividend     in   DIVIDEND_W  unsigned, captured on accepted start
//  divisor      in   DIVISOR_W   unsigned, captured on accepted start
//  busy         out  1           high in RUN and DONE
//  done         out  1           one-cycle pulse; results valid from this cycle on
//  quotient     out  DIVIDEND_W  result, held until next accept
//  remainder    out  DIVISOR_W   result, held until next accept
//  div_by_zero  out  1           set with done when divisor==0; held until next accept
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0.
//  - Reset mid-operation aborts the division: no done pulse, all outputs return to reset values.
//  - FSM states:
//    - IDLE -> RUN on start.
//    - RUN -> DONE at the edge completing iteration DIVIDEND_W-1.
//    - DONE -> IDLE after one cycle.
//  - Accept (edge 0, IDLE & start):
//    - latch divisor; load shift reg {partial_rem=0, dividend}; count = 0.
//    - Clear div_by_zero; quotient/remainder keep old values until done.
//  - Iteration (edges 1..DIVIDEND_W):
//    - trial = {partial_rem, msb(dividend reg)} - {1'b0, divisor}, computed DIVISOR_W+1 bits wide.
//    - trial non-negative: partial_rem = trial[DIVISOR_W-1:0], shift in quotient bit 1.
//    - trial negative: restore (keep the shifted partial remainder), shift in quotient bit 0.
//  - Latency: done=1 in the cycle after edge DIVIDEND_W (8 for the default), i.e. DIVIDEND_W clocks after the accept edge.
//    - quotient/remainder update at that same edge.
//  - Divide by zero:
//    - detected at accept; iterations are skipped; DONE is entered at edge 1.
//    - Results: quotient = all ones, remainder = 0, div_by_zero = 1.
//  - start while busy (RUN or DONE) is ignored; it is not queued.
//    - start in the same cycle done is high is also ignored; a new start is accepted from IDLE.
//  - dividend < divisor: quotient = 0, remainder = dividend (fits DIVISOR_W).
//  - Back-to-back: minimum start-to-start spacing is DIVIDEND_W+2 cycles.
// STRUCTURE
//  - Package div_pkg:
//    - state enum {IDLE, RUN, DONE};
//    - default widths DIVIDEND_W=8, DIVISOR_W=4;
//    - counter width localparam CNT_W = $clog2(DIVIDEND_W+1).
//  - Sub-module div_step (combinational):
//    - inputs: partial_rem, next dividend bit, divisor.
//    - outputs: new partial_rem, quotient bit.
//    - Instantiated once; the top level holds the FSM, counter and shift registers.
// TESTING
//  - 200/7 -> done after 8 clocks, quotient=28, remainder=4, div_by_zero=0, busy high for 9 cycles.
//  - 255/15 -> q=17, r=0; 5/9 -> q=0, r=5; 1/1 -> q=1, r=0; 0/3 -> q=0, r=0.
//  - 13/0 -> done one cycle after accept, q=8'hFF, r=0, div_by_zero=1.
//  - 200/7 then start with 100/3 pulsed at cycle 3 -> ignored; results still 28/4; next start from IDLE gives q=33, r=1.
//  - rst_n low at cycle 4 of 200/7 -> outputs 0 immediately, no done; fresh 9/2 afterward -> q=4, r=1.
//  - Random sweep of all 8b x 4b pairs -> q*d + r == dividend, r < d, done exactly once per accept.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DEF_DIVIDEND_W = 8;
  localparam int unsigned DEF_DIVISOR_W  = 4;
  localparam int unsigned CNT_W          = $clog2(DEF_DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial remainder.
module div_step #(
  parameter int unsigned DIVISOR_W = 4
) (
  input  logic [DIVISOR_W-1:0] partial_rem,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] next_rem_c,
  output logic                 q_bit_c
);

  localparam int unsigned TW = DIVISOR_W + 1;

  logic [TW-1:0] shifted;
  logic [TW:0]   trial;
  logic          unused_trial_bit;

  // The extra top bit of trial is the borrow; partial_rem < divisor keeps the rest in range.
  always_comb begin
    shifted    = {partial_rem, dividend_bit};
    trial      = {1'b0, shifted} - {2'b00, divisor};
    q_bit_c    = ~trial[TW];
    next_rem_c = q_bit_c ? trial[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
  end

  assign unused_trial_bit = trial[DIVISOR_W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
module seq_restoring_divider #(
  parameter int unsigned DIVIDEND_W = div_pkg::DEF_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = div_pkg::DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  import div_pkg::*;

  localparam int unsigned CNT_BITS = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(DIVIDEND_W - 1);

  state_e                state_q, state_d;
  logic                  accept, step, finish, zero_finish;

  logic [DIVISOR_W-1:0]  divisor_q;
  logic [DIVISOR_W-1:0]  prem_q;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [CNT_BITS-1:0]   count_q;
  logic                  zero_q;

  logic [DIVISOR_W-1:0]  next_rem;
  logic                  q_bit;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .partial_rem  (prem_q),
    .dividend_bit (dvd_q[DIVIDEND_W-1]),
    .divisor      (divisor_q),
    .next_rem_c   (next_rem),
    .q_bit_c      (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the datapath strobes for this edge.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    zero_finish = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (zero_q) begin
          zero_finish = 1'b1;
          state_d     = DONE;
        end else begin
          step = 1'b1;
          if (count_q == LAST_ITER) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture, iteration shift registers and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor_q   <= '0;
      prem_q      <= '0;
      dvd_q       <= '0;
      count_q     <= '0;
      zero_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= finish | zero_finish;

      if (accept) begin
        divisor_q   <= divisor;
        prem_q      <= '0;
        dvd_q       <= dividend;
        count_q     <= '0;
        zero_q      <= (divisor == '0);
        div_by_zero <= 1'b0;
        busy        <= 1'b1;
      end

      if (step) begin
        prem_q  <= next_rem;
        dvd_q   <= {dvd_q[DIVIDEND_W-2:0], q_bit};
        count_q <= count_q + CNT_BITS'(1);
      end

      if (finish) begin
        quotient  <= {dvd_q[DIVIDEND_W-2:0], q_bit};
        remainder <= next_rem;
      end

      if (zero_finish) begin
        quotient    <= '1;
        remainder   <= '0;
        div_by_zero <= 1'b1;
      end

      if (state_q == DONE) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed vectors, ignored starts, reset abort, full sweep.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  seq_restoring_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int n_accepts = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        if (!e.dz)
          check("q*d+r", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
      end
    end
  end

  // Issue one division; optionally pulse a spurious start (100/3) n cycles after accept.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er, input int ign_at);
    exp_t e;
    int   nbusy;
    logic edz;
    edz = (b == 4'd0);
    @(posedge clk); #1;
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = ~a; divisor = ~b;
    e.a = a; e.b = b; e.q = eq; e.r = er; e.dz = edz;
    e.cyc = cyc + (edz ? 1 : 8);
    sb.push_back(e);
    n_accepts++;
    nbusy = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      nbusy++;
      @(posedge clk); #1;
      start = (n == ign_at);
      if (n == ign_at) begin
        dividend = 8'd100; divisor = 4'd3;
      end else begin
        dividend = ~a; divisor = ~b;
      end
    end
    check("busy_cycles", 32'(nbusy), edz ? 32'd2 : 32'd9);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int saved_done;
    logic [7:0] eq;
    logic [3:0] er;

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_by_zero", 32'(div_by_zero), 32'd0);

    run_op(8'd200, 4'd7,  8'd28, 4'd4, -1);
    run_op(8'd255, 4'd15, 8'd17, 4'd0, -1);
    run_op(8'd5,   4'd9,  8'd0,  4'd5, -1);
    run_op(8'd1,   4'd1,  8'd1,  4'd0, -1);
    run_op(8'd0,   4'd3,  8'd0,  4'd0, -1);
    run_op(8'd13,  4'd0,  8'hFF, 4'd0, -1);
    check("held_div_by_zero", 32'(div_by_zero), 32'd1);
    check("held_quotient", 32'(quotient), 32'd255);

    // Spurious start during RUN, then during the done cycle; both must be dropped.
    run_op(8'd200, 4'd7,  8'd28, 4'd4, 2);
    run_op(8'd100, 4'd3,  8'd33, 4'd1, -1);
    run_op(8'd255, 4'd15, 8'd17, 4'd0, 8);
    run_op(8'd100, 4'd3,  8'd33, 4'd1, -1);

    // Reset in the middle of 200/7 aborts with no done pulse.
    saved_done = n_done;
    @(posedge clk); #1;
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_div_by_zero", 32'(div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(n_done), 32'(saved_done));
    run_op(8'd9, 4'd2, 8'd4, 4'd1, -1);

    // Exhaustive 8b x 4b sweep.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 8'hFF; er = 4'd0;
        end else begin
          eq = 8'(a / b); er = 4'(a % b);
        end
        run_op(8'(a), 4'(b), eq, er, -1);
      end
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("done_per_accept", 32'(n_done), 32'(n_accepts));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
